// File: rtl/stream_packer_pkg.sv
// Shared types and helpers for the stream packer and its scoreboards.
package stream_packer_pkg;

  // Default geometry: three 12-bit samples per 36-bit word.
  localparam int unsigned DefW     = 36;
  localparam int unsigned DefIW    = 12;
  localparam int unsigned DefRatio = DefW / DefIW;
  localparam int unsigned DefCW    = $clog2(DefRatio + 1);

  typedef logic [DefCW-1:0] lane_cnt_t;

  // Bitmask with one bit set per valid lane, lane 0 in bit 0.
  function automatic logic [31:0] lane_mask(input int unsigned lanes);
    logic [31:0] m;
    if (lanes >= 32) begin
      m = '1;
    end else begin
      m = (32'd1 << lanes) - 32'd1;
    end
    return m;
  endfunction

endpackage

// File: rtl/stream_packer.sv
// Packs pIW-bit samples into pW-bit words with frame alignment and flush.
// No backpressure: the consumer always accepts a word on an enabled edge.
module stream_packer
  import stream_packer_pkg::*;
#(
  parameter int unsigned pW       = DefW,
  parameter int unsigned pIW      = DefIW,
  localparam int unsigned pRATIO  = pW / pIW,
  localparam int unsigned pCW     = $clog2(pRATIO + 1)
) (
  input  logic           iclk,
  input  logic           irst_n,
  input  logic           iclk_ena,
  input  logic           iena,
  input  logic [pIW-1:0] idat,
  input  logic           isop,
  input  logic           iflush,
  output logic           oena,
  output logic [pW-1:0]  odat,
  output logic           osop,
  output logic [pCW-1:0] olanes
);

  if ((pW % pIW) != 0 || pW < pIW) begin : g_bad_ratio
    $error("stream_packer: pW must be a non-zero integer multiple of pIW");
  end

  logic [pW-1:0]  r_acc;
  logic [pCW-1:0] r_cnt;
  logic           r_sop;
  logic           r_oena;
  logic [pW-1:0]  r_odat;
  logic           r_osop;
  logic [pCW-1:0] r_olanes;

  logic [pW-1:0]  w_acc_new;
  logic [pCW-1:0] w_cnt_new;
  logic [pW-1:0]  w_acc_d;
  logic [pCW-1:0] w_cnt_d;
  logic           w_sop_d;
  logic           w_oena_d;
  logic [pW-1:0]  w_odat_d;
  logic           w_osop_d;
  logic [pCW-1:0] w_olanes_d;

  // Next-word assembly: merge the incoming sample and decide what leaves this edge.
  always_comb begin
    w_acc_new = r_acc;
    for (int k = 0; k < int'(pRATIO); k++) begin
      if (pCW'(k) == r_cnt) begin
        w_acc_new[k*pIW +: pIW] = idat;
      end
    end
    w_cnt_new = r_cnt + pCW'(1);

    w_acc_d    = r_acc;
    w_cnt_d    = r_cnt;
    w_sop_d    = r_sop;
    w_oena_d   = 1'b0;
    w_olanes_d = '0;
    w_odat_d   = r_odat;
    w_osop_d   = r_osop;

    if (iena && isop) begin
      // Older partial leaves now; the sop sample starts a fresh word.
      if (r_cnt != '0) begin
        w_oena_d   = 1'b1;
        w_odat_d   = r_acc;
        w_olanes_d = r_cnt;
        w_osop_d   = r_sop;
      end
      w_acc_d            = '0;
      w_acc_d[pIW-1:0]   = idat;
      w_cnt_d            = pCW'(1);
      w_sop_d            = 1'b1;
      // Single-lane words complete immediately (r_cnt is always 0 here).
      if (pRATIO == 1) begin
        w_oena_d   = 1'b1;
        w_odat_d   = w_acc_d;
        w_olanes_d = pCW'(1);
        w_osop_d   = 1'b1;
        w_acc_d    = '0;
        w_cnt_d    = '0;
        w_sop_d    = 1'b0;
      end
    end else if (iena) begin
      if (w_cnt_new == pCW'(pRATIO) || iflush) begin
        w_oena_d   = 1'b1;
        w_odat_d   = w_acc_new;
        w_olanes_d = w_cnt_new;
        w_osop_d   = r_sop;
        w_acc_d    = '0;
        w_cnt_d    = '0;
        w_sop_d    = 1'b0;
      end else begin
        w_acc_d = w_acc_new;
        w_cnt_d = w_cnt_new;
      end
    end else if (iflush && r_cnt != '0) begin
      w_oena_d   = 1'b1;
      w_odat_d   = r_acc;
      w_olanes_d = r_cnt;
      w_osop_d   = r_sop;
      w_acc_d    = '0;
      w_cnt_d    = '0;
      w_sop_d    = 1'b0;
    end
  end

  // State and output registers; everything holds on disabled edges.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_sop    <= 1'b0;
      r_oena   <= 1'b0;
      r_odat   <= '0;
      r_osop   <= 1'b0;
      r_olanes <= '0;
    end else if (iclk_ena) begin
      r_acc    <= w_acc_d;
      r_cnt    <= w_cnt_d;
      r_sop    <= w_sop_d;
      r_oena   <= w_oena_d;
      r_odat   <= w_odat_d;
      r_osop   <= w_osop_d;
      r_olanes <= w_olanes_d;
    end
  end

  assign oena   = r_oena;
  assign odat   = r_odat;
  assign osop   = r_osop;
  assign olanes = r_olanes;

endmodule

// File: tb/tb_stream_packer.sv
// Directed self-checking bench for stream_packer (default 36/12 geometry).
module tb_stream_packer;
  import stream_packer_pkg::*;

  logic        iclk;
  logic        irst_n;
  logic        iclk_ena;
  logic        iena;
  logic [11:0] idat;
  logic        isop;
  logic        iflush;
  logic        oena;
  logic [35:0] odat;
  logic        osop;
  lane_cnt_t   olanes;

  int n_vec;
  int n_err;

  stream_packer dut (
    .iclk     (iclk),
    .irst_n   (irst_n),
    .iclk_ena (iclk_ena),
    .iena     (iena),
    .idat     (idat),
    .isop     (isop),
    .iflush   (iflush),
    .oena     (oena),
    .odat     (odat),
    .osop     (osop),
    .olanes   (olanes)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge with the given inputs; returns 1 time unit after the edge.
  task automatic cyc(input logic ce, input logic en, input logic sop, input logic fl,
                     input logic [11:0] dat);
    iclk_ena = ce;
    iena     = en;
    isop     = sop;
    iflush   = fl;
    idat     = dat;
    @(posedge iclk);
    #1;
    iclk_ena = 1'b1;
    iena     = 1'b0;
    isop     = 1'b0;
    iflush   = 1'b0;
    idat     = '0;
  endtask

  task automatic chk_word(input string tag, input logic [35:0] d, input int unsigned l,
                          input logic s);
    chk({tag, ".oena"}, 64'(oena), 64'd1);
    chk({tag, ".odat"}, 64'(odat), 64'(d));
    chk({tag, ".olanes"}, 64'(olanes), 64'(l));
    chk({tag, ".osop"}, 64'(osop), 64'(s));
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    irst_n   = 1'b0;
    iclk_ena = 1'b1;
    iena     = 1'b0;
    isop     = 1'b0;
    iflush   = 1'b0;
    idat     = '0;
    repeat (2) @(posedge iclk);
    #1;
    chk("rst.oena", 64'(oena), 64'd0);
    chk("rst.odat", 64'(odat), 64'd0);
    chk("rst.olanes", 64'(olanes), 64'd0);
    chk("rst.osop", 64'(osop), 64'd0);
    @(negedge iclk);
    irst_n = 1'b1;

    chk("mask1", lane_mask(1), 64'h1);
    chk("mask3", lane_mask(3), 64'h7);

    // Three back-to-back samples make one full word.
    cyc(1, 1, 0, 0, 12'h001);
    chk("t1.s1.oena", 64'(oena), 64'd0);
    cyc(1, 1, 0, 0, 12'h002);
    chk("t1.s2.oena", 64'(oena), 64'd0);
    cyc(1, 1, 0, 0, 12'h003);
    chk_word("t1.w", 36'h003002001, 3, 1'b0);
    cyc(1, 0, 0, 0, 12'h000);
    chk("t1.idle.oena", 64'(oena), 64'd0);
    chk("t1.idle.olanes", 64'(olanes), 64'd0);

    // Clock enable toggling: word identical, oena held across disabled edge.
    cyc(1, 1, 0, 0, 12'h001);
    cyc(0, 0, 0, 0, 12'h000);
    cyc(1, 1, 0, 0, 12'h002);
    cyc(0, 0, 0, 0, 12'h000);
    chk("t2.pre.oena", 64'(oena), 64'd0);
    cyc(1, 1, 0, 0, 12'h003);
    chk_word("t2.w", 36'h003002001, 3, 1'b0);
    cyc(0, 0, 0, 0, 12'h000);
    chk("t2.hold.oena", 64'(oena), 64'd1);
    chk("t2.hold.olanes", 64'(olanes), 64'd3);
    cyc(1, 0, 0, 0, 12'h000);
    chk("t2.clr.oena", 64'(oena), 64'd0);

    // isop mid-word emits the partial and starts a new framed word.
    cyc(1, 1, 0, 0, 12'hAAA);
    cyc(1, 1, 0, 0, 12'hBBB);
    cyc(1, 1, 1, 0, 12'hCCC);
    chk_word("t3.w1", 36'h000BBBAAA, 2, 1'b0);
    cyc(1, 1, 0, 0, 12'hDDD);
    chk("t3.mid.oena", 64'(oena), 64'd0);
    cyc(1, 1, 0, 0, 12'hEEE);
    chk_word("t3.w2", 36'hEEEDDDCCC, 3, 1'b1);

    // Flush alone on a partial, then on empty state.
    cyc(1, 1, 0, 0, 12'h111);
    cyc(1, 0, 0, 1, 12'h000);
    chk_word("t4.w", 36'h000000111, 1, 1'b0);
    cyc(1, 0, 0, 1, 12'h000);
    chk("t4.empty.oena", 64'(oena), 64'd0);

    // Flush together with a sample includes the sample first.
    cyc(1, 1, 0, 0, 12'h111);
    cyc(1, 1, 0, 1, 12'h222);
    chk_word("t5.w", 36'h000222111, 2, 1'b0);
    cyc(1, 0, 0, 1, 12'h000);
    chk("t5.empty.oena", 64'(oena), 64'd0);

    // Flush with isop: only the older partial is flushed; sop sample is held.
    cyc(1, 1, 0, 0, 12'h001);
    cyc(1, 1, 0, 0, 12'h002);
    cyc(1, 1, 1, 1, 12'h003);
    chk_word("t6.w1", 36'h000002001, 2, 1'b0);
    cyc(1, 0, 0, 1, 12'h000);
    chk_word("t6.w2", 36'h000000003, 1, 1'b1);

    // Asynchronous reset mid-word discards the partial.
    cyc(1, 1, 0, 0, 12'h123);
    cyc(1, 1, 0, 0, 12'h456);
    #2;
    irst_n = 1'b0;
    #1;
    chk("t7.rst.oena", 64'(oena), 64'd0);
    chk("t7.rst.odat", 64'(odat), 64'd0);
    chk("t7.rst.osop", 64'(osop), 64'd0);
    chk("t7.rst.olanes", 64'(olanes), 64'd0);
    @(negedge iclk);
    irst_n = 1'b1;
    cyc(1, 1, 0, 0, 12'h007);
    cyc(1, 1, 0, 0, 12'h008);
    chk("t7.mid.oena", 64'(oena), 64'd0);
    cyc(1, 1, 0, 0, 12'h009);
    chk_word("t7.w", 36'h009008007, 3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
